// File: rtl/cpu_pkg.sv
// Shared processor constants: FSM state encoding and default datapath width.
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    HOLD    = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 8;

endpackage

// File: rtl/neg_unit.sv
// Combinational 2's complement negation, y = ~a + 1 (mod 2^WIDTH).
module neg_unit import cpu_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] y
);

  assign y = ~a + WIDTH'(1);

endmodule

// File: rtl/twoscomp_arbiter.sv
// Arbitrates NREQ requesters onto one shared negation datapath; holds the tagged
// result until ACK. Define TWOSCOMP_ARB_RR_EN for round-robin, else fixed priority.
module twoscomp_arbiter import cpu_pkg::*; #(
  parameter int NREQ  = 4,
  parameter int WIDTH = DEF_WIDTH,
  parameter int IDW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [NREQ-1:0]       REQ,
  input  logic [NREQ*WIDTH-1:0] OPERAND,
  output logic [NREQ-1:0]       GNT,
  input  logic                  ACK,
  output logic [WIDTH-1:0]      RESULT,
  output logic                  RESULT_VALID,
  output logic [IDW-1:0]        RESULT_ID,
  output logic                  BUSY
);

  state_t                       state;
  logic [NREQ-1:0][WIDTH-1:0]   ops;
  logic [WIDTH-1:0]             op_q;
  logic [WIDTH-1:0]             neg;
  logic [IDW-1:0]               id_q;
  logic [IDW-1:0]               start;
  logic [IDW-1:0]               win_id;
  logic [IDW-1:0]               idx;
  logic [IDW:0]                 sum;
  logic                         win_found;
  logic                         window;
  logic                         take;

  assign ops = OPERAND;

`ifdef TWOSCOMP_ARB_RR_EN
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] ptr_nxt;
  assign start   = ptr;
  assign ptr_nxt = (win_id == IDW'(NREQ - 1)) ? '0 : win_id + IDW'(1);
`else
  assign start = '0;
`endif

  // Scan from start, wrapping modulo NREQ; first requester found wins.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    sum       = '0;
    idx       = '0;
    for (int k = 0; k < NREQ; k++) begin
      sum = {1'b0, start} + (IDW+1)'(k);
      if (sum >= (IDW+1)'(NREQ)) sum = sum - (IDW+1)'(NREQ);
      idx = sum[IDW-1:0];
      if (!win_found && REQ[idx]) begin
        win_found = 1'b1;
        win_id    = idx;
      end
    end
  end

  assign window = (state == IDLE) || ((state == HOLD) && ACK);
  assign take   = window && win_found;

  always_comb begin
    GNT = '0;
    if (take && !RESET) GNT[win_id] = 1'b1;
  end

  assign BUSY = (state != IDLE);

  neg_unit #(.WIDTH(WIDTH)) u_neg (
    .a (op_q),
    .y (neg)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state        <= IDLE;
      op_q         <= '0;
      id_q         <= '0;
      RESULT       <= '0;
      RESULT_VALID <= 1'b0;
      RESULT_ID    <= '0;
`ifdef TWOSCOMP_ARB_RR_EN
      ptr          <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (take) begin
            op_q  <= ops[win_id];
            id_q  <= win_id;
            state <= COMPUTE;
          end
        end
        COMPUTE: begin
          RESULT       <= neg;
          RESULT_VALID <= 1'b1;
          RESULT_ID    <= id_q;
          state        <= HOLD;
        end
        HOLD: begin
          if (ACK) begin
            RESULT_VALID <= 1'b0;
            if (take) begin
              op_q  <= ops[win_id];
              id_q  <= win_id;
              state <= COMPUTE;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
`ifdef TWOSCOMP_ARB_RR_EN
      if (take) ptr <= ptr_nxt;
`endif
    end
  end

endmodule
